// File: rtl/prbs_scrambler_par_pkg.sv
// Shared constants and FSM state type for the parallel PRBS scrambler.
package prbs_pkg;

  localparam logic [14:0] PRBS15_TAPS = 15'h6000;
  localparam logic [14:0] PRBS15_SEED = 15'h4A80;

  localparam int BEAT_CNT_W = 16;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

endpackage

// File: rtl/prbs_scrambler_par_lfsr_step.sv
// Combinational DATA_W-step unroll of a Fibonacci LFSR; keystream bit k is the
// feedback bit produced by step k.
module prbs_lfsr_step #(
  parameter int          LFSR_LEN = 15,
  parameter logic [31:0] TAPS     = 32'h0000_6000,
  parameter int          DATA_W   = 8
) (
  input  logic [LFSR_LEN-1:0] lfsr_in,
  output logic [DATA_W-1:0]   keystream,
  output logic [LFSR_LEN-1:0] lfsr_out
);

  localparam logic [LFSR_LEN-1:0] TAPS_M = TAPS[LFSR_LEN-1:0];

  logic [LFSR_LEN-1:0] s;
  logic                fb;

  always_comb begin
    s         = lfsr_in;
    fb        = 1'b0;
    keystream = '0;
    for (int k = 0; k < DATA_W; k++) begin
      fb           = ^(s & TAPS_M);
      keystream[k] = fb;
      s            = {s[LFSR_LEN-2:0], fb};
    end
    lfsr_out = s;
  end

endmodule

// File: rtl/prbs_scrambler_par.sv
// Frame-aware parallel PRBS scrambler with valid/ready on both sides.
// Optional per-frame beat counter enabled by PRBS_SCRAMBLER_BEAT_CNT_EN.
module prbs_scrambler_par
  import prbs_pkg::*;
#(
  parameter int          LFSR_LEN = 15,
  parameter logic [31:0] TAPS     = 32'(PRBS15_TAPS),
  parameter logic [31:0] SEED     = 32'(PRBS15_SEED),
  parameter int          DATA_W   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  seed_load,
  input  logic [LFSR_LEN-1:0]   seed_in,
  input  logic                  bypass,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_W-1:0]     s_data,
  input  logic                  s_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_W-1:0]     m_data,
  output logic                  m_last
`ifdef PRBS_SCRAMBLER_BEAT_CNT_EN
  ,
  output logic [BEAT_CNT_W-1:0] beat_cnt,
  output logic                  frame_done
`endif
);

  localparam logic [LFSR_LEN-1:0] SEED_M = SEED[LFSR_LEN-1:0];

  state_t              state, state_next;
  logic [LFSR_LEN-1:0] seed_reg;
  logic [LFSR_LEN-1:0] lfsr, lfsr_next;
  logic [LFSR_LEN-1:0] step_in, step_out;
  logic [DATA_W-1:0]   keystream;
  logic                accept;

  assign s_ready = !reset && (!m_valid || m_ready);
  assign accept  = s_valid && s_ready;
  assign step_in = (state == IDLE) ? seed_reg : lfsr;

  prbs_lfsr_step #(
    .LFSR_LEN (LFSR_LEN),
    .TAPS     (TAPS),
    .DATA_W   (DATA_W)
  ) u_step (
    .lfsr_in   (step_in),
    .keystream (keystream),
    .lfsr_out  (step_out)
  );

  // A bypassed frame-start beat still anchors the keystream at the seed.
  always_comb begin
    state_next = state;
    lfsr_next  = lfsr;
    if (accept) begin
      if (!bypass) begin
        lfsr_next = step_out;
      end else if (state == IDLE) begin
        lfsr_next = seed_reg;
      end
      state_next = s_last ? IDLE : RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      seed_reg <= SEED_M;
      lfsr     <= SEED_M;
      m_valid  <= 1'b0;
      m_data   <= '0;
      m_last   <= 1'b0;
    end else begin
      state <= state_next;
      lfsr  <= lfsr_next;
      if (seed_load && (seed_in != '0)) begin
        seed_reg <= seed_in;
      end
      if (accept) begin
        m_valid <= 1'b1;
        m_data  <= bypass ? s_data : (s_data ^ keystream);
        m_last  <= s_last;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

`ifdef PRBS_SCRAMBLER_BEAT_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      beat_cnt   <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= accept && s_last;
      if (accept) begin
        if (s_last) begin
          beat_cnt <= '0;
        end else if (beat_cnt != '1) begin
          beat_cnt <= beat_cnt + 1'b1;
        end
      end
    end
  end
`endif

endmodule
